prog_loader: RTL

Instruction-memory program loader for the 8-bit processor. Receives a byte stream over a valid/ready handshake, assembles 16-bit instruction words (high byte first) and writes them into instruction memory on the write port that complements the fetch-side read port. Holds the processor (`cpu_hold`) until a complete program has been written, then releases it.

---
 rtl/prog_loader_pkg.sv | 26 ++
 rtl/prog_loader_if.sv | 28 ++
 rtl/prog_loader_chk.sv | 28 ++
 rtl/prog_loader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional checksum support is selected with PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = 2;
  localparam int WORD_W         = BYTE_W * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HI    = 3'd1,
    LO    = 3'd2,
    WRITE = 3'd3,
    CHK   = 3'd4,
    DONE  = 3'd5,
    ERR   = 3'd6
  } state_e;

  // A zero header means "fill the whole memory".
  function automatic int unsigned hdr_to_count(input logic [BYTE_W-1:0] hdr,
                                               input int unsigned addr_w);
    if (hdr == '0) return 32'd1 << addr_w;
    return {24'd0, hdr};
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and processor status of the loader.
// Stream handshake: a byte moves on every rising edge where byte_valid && byte_ready;
// byte_ready never depends on byte_valid, and byte_in is ignored when no transfer happens.
interface prog_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              start;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  modport master (
    output byte_in, byte_valid, start,
    input  byte_ready, mem_wr, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );

  modport slave (
    input  byte_in, byte_valid, start,
    output byte_ready, mem_wr, mem_addr, mem_wdata, cpu_hold, load_done, load_err
  );
endinterface

// File: rtl/prog_loader_chk.sv
// 8-bit XOR accumulator over the loaded stream; clear has priority over accumulate.
module prog_loader_chk
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [BYTE_W-1:0] acc_o
);

  logic [BYTE_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = acc_q ^ byte_i;
  end

  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Loads a header-prefixed byte stream into instruction memory and holds the CPU until done.
// Define PROG_LOADER_CHECKSUM_EN to require and verify a trailing XOR checksum byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int BASE_ADDR = 0
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus,
  output state_e        state_o
);

  // Wide enough to hold both a full 8-bit header count and 2^ADDR_W.
  localparam int CNT_W = ((ADDR_W > BYTE_W) ? ADDR_W : BYTE_W) + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_inc;
  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] lo_q, lo_d;
  logic              rst_q;
  logic              byte_ready_w;
  logic              accept;
  logic              rearm;
  logic [WORD_W-1:0] word;

  assign byte_ready_w = (state_q inside {IDLE, HI, LO, CHK}) && !rst_q;
  assign accept       = bus.byte_valid && byte_ready_w;
  assign rearm        = bus.start && (state_q inside {DONE, ERR});
  assign idx_inc      = idx_q + CNT_W'(1);

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0] acc;
  logic              acc_en;

  assign acc_en = accept && (state_q inside {IDLE, HI, LO});

  prog_loader_chk u_chk (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (rearm),
    .en_i   (acc_en),
    .byte_i (bus.byte_in),
    .acc_o  (acc)
  );
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: if (accept) begin
        cnt_d   = CNT_W'(hdr_to_count(bus.byte_in, ADDR_W));
        idx_d   = '0;
        state_d = HI;
      end
      HI: if (accept) begin
        hi_d    = bus.byte_in;
        state_d = LO;
      end
      LO: if (accept) begin
        lo_d    = bus.byte_in;
        state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_inc;
        if (idx_inc == cnt_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = DONE;
`endif
        end else begin
          state_d = HI;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (accept) begin
        state_d = (bus.byte_in == acc) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (rearm) begin
        state_d = IDLE;
        idx_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Address arithmetic is done at ADDR_W bits so it wraps without notice.
  assign word          = {hi_q, lo_q};
  assign bus.byte_ready = byte_ready_w;
  assign bus.mem_wr    = (state_q == WRITE);
  assign bus.mem_addr  = ADDR_W'(BASE_ADDR) + idx_q[ADDR_W-1:0];
  assign bus.mem_wdata = DATA_W'(word);
  assign bus.cpu_hold  = (state_q != DONE) || rst_q;
  assign bus.load_done = (state_q == DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
  assign bus.load_err  = (state_q == ERR);
`else
  assign bus.load_err  = 1'b0;
`endif
  assign state_o = state_q;

endmodule
